// File: rtl/avalon_mm_regfile.sv
// Avalon-MM pipelined slave register bank with byte enables, fixed read
// latency, read stall on read+write collision and read-only registers.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   address/read/write    Avalon-MM request (word address)
//   writedata/byteenable  write data and byte-lane enables
//   waitrequest           read stall (read & write)
//   readdata/valid        read response, READ_LATENCY cycles after accept
//   regs_out              flattened register contents (RW regs or hw_in)
//   hw_in                 hardware values for read-only registers
//   wr_pulse              one-cycle strobe per RW register written
//   response              (AVMM_REGFILE_RESPONSE_EN) 00 OKAY, 10 SLVERR
//
// Optional macro: AVMM_REGFILE_RESPONSE_EN adds the response port.

module avalon_mm_regfile #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    NUM_REGS     = 16,
    parameter int                    READ_LATENCY = 2,
    parameter logic [NUM_REGS-1:0]   RO_MASK      = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic                           read,
    input  logic                           write,
    input  logic [DATA_WIDTH-1:0]          writedata,
    input  logic [DATA_WIDTH/8-1:0]        byteenable,
    output logic                           waitrequest,
    output logic [DATA_WIDTH-1:0]          readdata,
    output logic                           readdatavalid,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS-1:0]            wr_pulse
`ifdef AVMM_REGFILE_RESPONSE_EN
    ,
    output logic [1:0]                     response
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] LP_NREGS = (ADDR_WIDTH + 1)'(NUM_REGS);

    if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_chk_lat
        $error("READ_LATENCY must be in 1..4");
    end

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;
    logic                  r_vld  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_dat  [READ_LATENCY];

    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_ro;
    logic                  w_wait;
    logic                  w_wr_hit;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Full-width compare: upper address bits must not alias into the bank.
    assign w_in_range = ({1'b0, address} < LP_NREGS);
    assign w_idx      = address[IDX_W-1:0];
    assign w_ro       = w_in_range & RO_MASK[w_idx];

    // Write wins a collision; the read is held until write drops.
    assign w_wait   = rst_n & read & write;
    assign w_wr_hit = rst_n & write & w_in_range & ~w_ro;
    assign w_rd_acc = rst_n & read & ~w_wait;

    assign waitrequest = w_wait;

    always_comb begin
        w_rd_data = '0;
        if (w_in_range) begin
            if (w_ro) begin
                w_rd_data = hw_in[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_rd_data = r_regs[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else if (w_wr_hit) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    r_regs[w_idx][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    // Pulse fires even with byteenable=0: the access itself is the event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_pulse <= '0;
        end else if (w_wr_hit) begin
            r_wr_pulse <= NUM_REGS'(1) << w_idx;
        end else begin
            r_wr_pulse <= '0;
        end
    end

    assign wr_pulse = r_wr_pulse;

    // Fixed-depth shift pipeline; stage 0 holds the data captured at accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            r_dat[0] <= w_rd_acc ? w_rd_data : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign readdatavalid = r_vld[READ_LATENCY-1];
    assign readdata      = r_vld[READ_LATENCY-1] ?
                           r_dat[READ_LATENCY-1] : '0;

`ifdef AVMM_REGFILE_RESPONSE_EN
    logic r_err [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_err[i] <= 1'b0;
            end
        end else begin
            r_err[0] <= w_rd_acc & ~w_in_range;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_err[i] <= r_err[i-1];
            end
        end
    end

    assign response = (r_vld[READ_LATENCY-1] && r_err[READ_LATENCY-1]) ?
                      2'b10 : 2'b00;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        if (RO_MASK[g]) begin : g_ro
            assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] =
                rst_n ? hw_in[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        end else begin : g_rw
            assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
        end
    end

endmodule

// File: tb/tb_avalon_mm_regfile.sv
// Directed testbench for avalon_mm_regfile: vector table plus hand-written
// sequences for collision, back-to-back reads and reset during a read.

module tb_avalon_mm_regfile;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;
    localparam int RL = 3;
    localparam logic [DW-1:0] RV = 32'hA5A5_0000;

    logic              clk;
    logic              rst_n;
    logic [AW-1:0]     address;
    logic              read;
    logic              write;
    logic [DW-1:0]     writedata;
    logic [DW/8-1:0]   byteenable;
    logic              waitrequest;
    logic [DW-1:0]     readdata;
    logic              readdatavalid;
    logic [NR*DW-1:0]  regs_out;
    logic [NR*DW-1:0]  hw_in;
    logic [NR-1:0]     wr_pulse;
`ifdef AVMM_REGFILE_RESPONSE_EN
    logic [1:0]        response;
`endif

    int n_vec = 0;
    int n_bad = 0;

    avalon_mm_regfile #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .NUM_REGS     (NR),
        .READ_LATENCY (RL),
        .RO_MASK      (16'h0004),
        .RESET_VALUE  (RV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .regs_out      (regs_out),
        .hw_in         (hw_in),
        .wr_pulse      (wr_pulse)
`ifdef AVMM_REGFILE_RESPONSE_EN
        ,
        .response      (response)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
        logic [DW-1:0] exp;
        logic [NR-1:0] pulse;
        logic [1:0]    resp;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] reg_of(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    task automatic do_write(input vec_t v);
        address    = v.addr;
        writedata  = v.wdata;
        byteenable = v.be;
        write      = 1'b1;
        #1;
        chk("wr_nostall", 64'(waitrequest), 64'(0));
        tick();
        write = 1'b0;
        chk("wr_pulse", 64'(wr_pulse), 64'(v.pulse));
        if (v.addr < NR) begin
            chk("wr_reg", 64'(reg_of(int'(v.addr))), 64'(v.exp));
        end
        tick();
        chk("wr_pulse_off", 64'(wr_pulse), 64'(0));
    endtask

    task automatic do_read(input vec_t v);
        address = v.addr;
        read    = 1'b1;
        tick();
        read = 1'b0;
        for (int j = 0; j < RL; j++) begin
            if (j < RL - 1) begin
                chk("rd_early", {31'd0, readdatavalid, readdata},
                    64'(0));
                tick();
            end else begin
                chk("rd_data", {31'd0, readdatavalid, readdata},
                    {31'd0, 1'b1, v.exp});
`ifdef AVMM_REGFILE_RESPONSE_EN
                chk("rd_resp", 64'(response), 64'(v.resp));
`endif
                tick();
                chk("rd_after", 64'(readdatavalid), 64'(0));
            end
        end
    endtask

    initial begin
        logic seen;

        vt[0]  = '{1'b0, 8'd3,   32'h0,         4'h0, RV,            16'h0000, 2'b00};
        vt[1]  = '{1'b1, 8'd5,   32'h0,         4'hF, 32'h0,         16'h0020, 2'b00};
        vt[2]  = '{1'b1, 8'd5,   32'h1122_3344, 4'h5, 32'h0022_0044, 16'h0020, 2'b00};
        vt[3]  = '{1'b0, 8'd5,   32'h0,         4'h0, 32'h0022_0044, 16'h0000, 2'b00};
        vt[4]  = '{1'b1, 8'd1,   32'hCAFE_F00D, 4'h0, RV,            16'h0002, 2'b00};
        vt[5]  = '{1'b1, 8'd1,   32'hCAFE_F00D, 4'h8, 32'hCAA5_0000, 16'h0002, 2'b00};
        vt[6]  = '{1'b1, 8'd2,   32'hFFFF_FFFF, 4'hF, 32'h0000_CAFE, 16'h0000, 2'b00};
        vt[7]  = '{1'b0, 8'd2,   32'h0,         4'h0, 32'h0000_CAFE, 16'h0000, 2'b00};
        vt[8]  = '{1'b1, 8'd200, 32'hFFFF_FFFF, 4'hF, 32'h0,         16'h0000, 2'b00};
        vt[9]  = '{1'b0, 8'd200, 32'h0,         4'h0, 32'h0,         16'h0000, 2'b10};
        vt[10] = '{1'b1, 8'd15,  32'h1234_5678, 4'hF, 32'h1234_5678, 16'h8000, 2'b00};
        vt[11] = '{1'b0, 8'd15,  32'h0,         4'h0, 32'h1234_5678, 16'h0000, 2'b00};
        vt[12] = '{1'b0, 8'd16,  32'h0,         4'h0, 32'h0,         16'h0000, 2'b10};
        vt[13] = '{1'b0, 8'd1,   32'h0,         4'h0, 32'hCAA5_0000, 16'h0000, 2'b00};

        for (int i = 0; i < NR; i++) begin
            hw_in[i*DW +: DW] = 32'h5A5A_0000 + 32'(i);
        end
        hw_in[2*DW +: DW] = 32'h0000_CAFE;

        // Reset with both requests high: no stall, no write takes effect.
        rst_n      = 1'b0;
        read       = 1'b1;
        write      = 1'b1;
        address    = 8'd3;
        writedata  = 32'hFFFF_FFFF;
        byteenable = 4'hF;
        #1;
        chk("rst_wait", 64'(waitrequest), 64'(0));
        tick();
        tick();
        chk("rst_vld", 64'(readdatavalid), 64'(0));
        chk("rst_rdata", 64'(readdata), 64'(0));
        chk("rst_pulse", 64'(wr_pulse), 64'(0));
        chk("rst_ro_slot", 64'(reg_of(2)), 64'(0));
        chk("rst_rw_reg", 64'(reg_of(3)), 64'(RV));
`ifdef AVMM_REGFILE_RESPONSE_EN
        chk("rst_resp", 64'(response), 64'(0));
`endif
        read  = 1'b0;
        write = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_vld", 64'(readdatavalid), 64'(0));
        chk("ro_live", 64'(reg_of(2)), 64'(32'h0000_CAFE));

        for (int i = 0; i < 14; i++) begin
            if (vt[i].wr) do_write(vt[i]);
            else          do_read(vt[i]);
        end

        // Back-to-back reads of 0,1,2: three consecutive in-order responses.
        address = 8'd0;
        read    = 1'b1;
        tick();
        address = 8'd1;
        tick();
        chk("b2b_early", 64'(readdatavalid), 64'(0));
        address = 8'd2;
        tick();
        read = 1'b0;
        chk("b2b_0", {31'd0, readdatavalid, readdata}, {31'd0, 1'b1, RV});
        tick();
        chk("b2b_1", {31'd0, readdatavalid, readdata},
            {31'd0, 1'b1, 32'hCAA5_0000});
        tick();
        chk("b2b_2", {31'd0, readdatavalid, readdata},
            {31'd0, 1'b1, 32'h0000_CAFE});
        tick();
        chk("b2b_end", 64'(readdatavalid), 64'(0));

        // Read and write together: write goes first, read follows.
        address    = 8'd7;
        writedata  = 32'hDEAD_BEEF;
        byteenable = 4'hF;
        write      = 1'b1;
        read       = 1'b1;
        #1;
        chk("col_wait", 64'(waitrequest), 64'(1));
        tick();
        write = 1'b0;
        #1;
        chk("col_pulse", 64'(wr_pulse), 64'(16'h0080));
        chk("col_wait_off", 64'(waitrequest), 64'(0));
        tick();
        read = 1'b0;
        chk("col_early0", 64'(readdatavalid), 64'(0));
        tick();
        chk("col_early1", 64'(readdatavalid), 64'(0));
        tick();
        chk("col_data", {31'd0, readdatavalid, readdata},
            {31'd0, 1'b1, 32'hDEAD_BEEF});
        tick();

        // Reset right after a read is accepted: the response never appears.
        address = 8'd3;
        read    = 1'b1;
        tick();
        read  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen |= readdatavalid;
            tick();
        end
        chk("rst_flush", 64'(seen), 64'(0));
        chk("rst_reg5", 64'(reg_of(5)), 64'(RV));
        chk("rst_reg7", 64'(reg_of(7)), 64'(RV));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/avalon_mm_regfile.md
Name: avalon_mm_regfile

Overview:
- Parametrised Avalon-MM pipelined slave register bank, the next generation of the team's simple Avalon-MM slave interface.
- Adds byteenable, a configurable fixed read latency, waitrequest arbitration and per-register read-only masking.
- Exposes the register contents and per-register write strobes to the surrounding logic.
- Sits behind a fabric master, e.g. the loopback control path, as the block's CSR space.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word address width; 2**ADDR_WIDTH >= NUM_REGS.
- NUM_REGS, 16, number of implemented registers at word addresses 0..NUM_REGS-1.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid; legal range 1..4.
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from hw_in.
- RESET_VALUE, 0, DATA_WIDTH-bit reset value loaded into every RW register.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- address  in  ADDR_WIDTH  word address.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_WIDTH  write data.
- byteenable  in  DATA_WIDTH/8  write byte-lane enables.
- waitrequest  out  1  read stall.
- readdata  out  DATA_WIDTH  read data.
- readdatavalid  out  1  readdata qualifier.
- regs_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- hw_in  in  NUM_REGS*DATA_WIDTH  hardware values for RO registers, same packing as regs_out.
- wr_pulse  out  NUM_REGS  one-cycle strobe per RW register written.

Behaviour:
- Reset, when rst_n=0 at an edge:
  - RW registers <= RESET_VALUE; RO slots of regs_out drive 0.
  - readdatavalid=0, readdata=0, wr_pulse=0; read pipeline flushed.
  - A read in flight when reset asserts never returns data.
- waitrequest is combinational and equals read & write.
  - Writes are never stalled.
  - When both requests are asserted, the write is accepted and the read is held. The master drops write after acceptance; the read is accepted on the first cycle with write low.
  - waitrequest is 0 while rst_n=0.
- Write acceptance: write=1.
  - If address < NUM_REGS and RO_MASK[address]=0, each byte lane k with byteenable[k]=1 is updated at that edge.
  - wr_pulse[address] goes high for exactly the following cycle, including when byteenable=0.
  - Writes to RO or out-of-range addresses are ignored and give no pulse.
- Read acceptance: read & ~waitrequest. Data is captured at the acceptance edge:
  - RW register: current stored value, including a write completed on the previous edge.
  - RO register: hw_in slice.
  - address >= NUM_REGS: all zeros.
- Read latency:
  - readdatavalid=1 exactly READ_LATENCY cycles after the acceptance edge, with the captured data on readdata.
  - Shift-pipeline of depth READ_LATENCY; one read per cycle sustained, responses in order.
  - readdata=0 whenever readdatavalid=0.
- There is no response backpressure. Pipeline occupancy never exceeds READ_LATENCY, so there are no full or empty conditions.
- Address is not decoded modulo NUM_REGS; aliasing is forbidden.
- regs_out is driven directly from registers (RW) or hw_in (RO), with no added latency.

Optional Feature:
- Macro: AVMM_REGFILE_RESPONSE_EN.
- Defined:
  - Adds output port response, 2 bits, aligned with readdatavalid.
  - 2'b00 OKAY for in-range reads; 2'b10 SLVERR for address >= NUM_REGS.
  - response=2'b00 when readdatavalid=0 and at reset.
- Undefined: no response port; out-of-range reads silently return 0.

Test Plan:
- Reset value: RESET_VALUE=32'hA5A5_0000, release rst_n, read addr 3 -> readdatavalid 2 cycles after acceptance, readdata=32'hA5A5_0000.
- Byte-lane write: write 32'h1122_3344 with byteenable=4'b0101 to addr 5 (was 0) -> regs_out reg5=32'h0022_0044; wr_pulse[5] high one cycle only.
- Back-to-back reads: reads addrs 0,1,2 on consecutive cycles with READ_LATENCY=3 -> three consecutive readdatavalid cycles, in order, data matches.
- Simultaneous read+write: write 32'hDEAD_BEEF to addr 7 with read addr 7 in the same cycle -> waitrequest=1 that cycle, write accepted; read accepted next cycle, returns 32'hDEAD_BEEF.
- RO and out-of-range: RO_MASK bit2=1, hw_in reg2=32'h0000_CAFE, write 32'hFFFF_FFFF to addr 2 -> read returns 32'h0000_CAFE, no wr_pulse[2]. Read addr 200 -> 0, and response=2'b10 with AVMM_REGFILE_RESPONSE_EN.
- Reset mid-read: accept read, assert rst_n=0 next cycle -> no readdatavalid ever issued for that read.
